// File: rtl/pfq_pkg.sv
// pfq_pkg: shared sizing helpers for the parametrised prefetch queue
package pfq_pkg;

    // bytes delivered per full bus fetch
    function automatic int bus_bytes(int bw);
        return bw / 8;
    endfunction

    // ring pointer width
    function automatic int ptr_w(int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // a + b mod m, valid while a < m and b <= m
    function automatic int unsigned mod_add(int unsigned a, int unsigned b, int unsigned m);
        int unsigned s;
        s = a + b;
        return (s >= m) ? s - m : s;
    endfunction

endpackage

// File: rtl/pfq_if.sv
// pfq_if: BIU/EU-facing signal bundle of the prefetch queue
// slave : the queue (inputs FLUSH, FLUSH_ADDR, WR_VALID, WR_DATA, POP, POP2; drives the rest)
// master: the bus state machine / EU side
interface pfq_if #(
    parameter int DEPTH     = 4,
    parameter int BUS_WIDTH = 8
);
    logic                         FLUSH;
    logic [15:0]                  FLUSH_ADDR;
    logic                         FETCH_REQ;
    logic [15:0]                  FETCH_ADDR;
    logic                         WR_VALID;
    logic [BUS_WIDTH-1:0]         WR_DATA;
    logic                         POP;
    logic                         POP2;
    logic [7:0]                   PFQ_TOP_BYTE;
    logic [7:0]                   PFQ_NEXT_BYTE;
    logic                         PFQ_EMPTY;
    logic                         PFQ_NEXT_VALID;
    logic [15:0]                  PFQ_ADDR_OUT;
    logic [$clog2(DEPTH+1)-1:0]   PFQ_COUNT;

    modport slave (
        input  FLUSH, FLUSH_ADDR, WR_VALID, WR_DATA, POP, POP2,
        output FETCH_REQ, FETCH_ADDR, PFQ_TOP_BYTE, PFQ_NEXT_BYTE,
               PFQ_EMPTY, PFQ_NEXT_VALID, PFQ_ADDR_OUT, PFQ_COUNT
    );

    modport master (
        output FLUSH, FLUSH_ADDR, WR_VALID, WR_DATA, POP, POP2,
        input  FETCH_REQ, FETCH_ADDR, PFQ_TOP_BYTE, PFQ_NEXT_BYTE,
               PFQ_EMPTY, PFQ_NEXT_VALID, PFQ_ADDR_OUT, PFQ_COUNT
    );
endinterface

// File: rtl/pfq_ring.sv
// pfq_ring: DEPTH-byte ring storage, 2-byte write at wa/wa+1, 2 read ports at ra/ra+1
// i_clk, i_rst_n : clock, sync active-low reset (clears storage)
// i_we0/i_wd0    : write byte at i_wa;  i_we1/i_wd1 : write byte at i_wa+1
// i_ra           : read address; o_rd0 = mem[ra], o_rd1 = mem[ra+1]
module pfq_ring
    import pfq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = ptr_w(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we0,
    input  logic          i_we1,
    input  logic [PW-1:0] i_wa,
    input  logic [7:0]    i_wd0,
    input  logic [7:0]    i_wd1,
    input  logic [PW-1:0] i_ra,
    output logic [7:0]    o_rd0,
    output logic [7:0]    o_rd1
);
    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] w_wa1;
    logic [PW-1:0] w_ra1;

    // second byte wraps independently, so a 2-byte write may split at the end
    assign w_wa1 = PW'(mod_add(32'(i_wa), 32'd1, DEPTH));
    assign w_ra1 = PW'(mod_add(32'(i_ra), 32'd1, DEPTH));
    assign o_rd0 = r_mem[i_ra];
    assign o_rd1 = r_mem[w_ra1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_we0) r_mem[i_wa] <= i_wd0;
            if (i_we1) r_mem[w_wa1] <= i_wd1;
        end
    end
endmodule

// File: rtl/pfq_param.sv
// pfq_param: parametrised BIU instruction prefetch queue (8088/8086 style)
// CORE_CLK, RESET_N : clock, sync active-low reset
// bus (pfq_if.slave): flush, fetch request/address, fill data, pop/pop2, EU view
module pfq_param
    import pfq_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter int          BUS_WIDTH  = 8,
    parameter logic [15:0] RESET_ADDR = 16'h0000
) (
    input  logic  CORE_CLK,
    input  logic  RESET_N,
    pfq_if.slave  bus
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int BB = bus_bytes(BUS_WIDTH);

    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [15:0]   r_top_ip;
    logic [15:0]   r_fetch_ip;

    logic [CW-1:0] w_fill;
    logic [CW-1:0] w_wn;
    logic [CW-1:0] w_rem;
    logic          w_wr;
    logic          w_we;
    logic [15:0]   w_wd;
    logic [7:0]    w_b0;

    // an odd fetch address on a 16-bit bus only yields the high byte
    assign w_fill = (BB == 1 || r_fetch_ip[0]) ? CW'(1) : CW'(2);
    assign bus.FETCH_REQ = (CW'(DEPTH) - r_count) >= w_fill;
    assign w_wr = bus.WR_VALID && bus.FETCH_REQ;
    assign w_we = w_wr && !bus.FLUSH;
    assign w_wn = w_wr ? w_fill : '0;
    assign w_rem = (bus.POP2 && r_count >= CW'(2)) ? CW'(2) :
                   ((bus.POP || bus.POP2) && r_count != '0) ? CW'(1) : '0;
    assign w_wd = 16'(bus.WR_DATA);
    assign w_b0 = (BB == 2 && r_fetch_ip[0]) ? w_wd[15:8] : w_wd[7:0];

    pfq_ring #(.DEPTH(DEPTH), .PW(PW)) u_ring (
        .i_clk   (CORE_CLK),
        .i_rst_n (RESET_N),
        .i_we0   (w_we),
        .i_we1   (w_we && w_fill == CW'(2)),
        .i_wa    (r_wr),
        .i_wd0   (w_b0),
        .i_wd1   (w_wd[15:8]),
        .i_ra    (r_rd),
        .o_rd0   (bus.PFQ_TOP_BYTE),
        .o_rd1   (bus.PFQ_NEXT_BYTE)
    );

    always_ff @(posedge CORE_CLK) begin
        if (!RESET_N) begin
            r_count    <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_top_ip   <= RESET_ADDR;
            r_fetch_ip <= RESET_ADDR;
        end else if (bus.FLUSH) begin
            r_count    <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_top_ip   <= bus.FLUSH_ADDR;
            r_fetch_ip <= bus.FLUSH_ADDR;
        end else begin
            r_count    <= r_count + w_wn - w_rem;
            r_rd       <= PW'(mod_add(32'(r_rd), 32'(w_rem), DEPTH));
            r_wr       <= PW'(mod_add(32'(r_wr), 32'(w_wn), DEPTH));
            r_top_ip   <= r_top_ip + 16'(w_rem);
            r_fetch_ip <= r_fetch_ip + 16'(w_wn);
        end
    end

    assign bus.FETCH_ADDR     = r_fetch_ip;
    assign bus.PFQ_ADDR_OUT   = r_top_ip;
    assign bus.PFQ_COUNT      = r_count;
    assign bus.PFQ_EMPTY      = r_count == '0;
    assign bus.PFQ_NEXT_VALID = r_count >= CW'(2);
endmodule

// File: tb/tb_pfq_param.sv
// tb_pfq_param: scoreboard bench for the 4-byte/8-bit and 6-byte/16-bit queue builds
module tb_pfq_param;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    pfq_if #(.DEPTH(4), .BUS_WIDTH(8))  ba();
    pfq_if #(.DEPTH(6), .BUS_WIDTH(16)) bb();

    pfq_param #(.DEPTH(4), .BUS_WIDTH(8),  .RESET_ADDR(16'h0000)) ua (.CORE_CLK(clk), .RESET_N(rst_a), .bus(ba));
    pfq_param #(.DEPTH(6), .BUS_WIDTH(16), .RESET_ADDR(16'h1230)) ub (.CORE_CLK(clk), .RESET_N(rst_b), .bus(bb));

    typedef struct {
        int          dut;
        string       nm;
        int          cnt;
        logic [15:0] addr;
        logic [15:0] fa;
        logic        rq;
        bit          ct;
        logic [7:0]  top;
        bit          cn;
        logic [7:0]  nx;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [7:0]  mq[$];
    logic [15:0] m_top;
    logic [15:0] m_fa;

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic ex(int dut, string nm, int cnt, logic [15:0] addr, logic [15:0] fa, logic rq,
                      bit ct = 0, logic [7:0] top = 8'h00, bit cn = 0, logic [7:0] nx = 8'h00);
        exp_t e;
        e.dut = dut; e.nm = nm; e.cnt = cnt; e.addr = addr; e.fa = fa; e.rq = rq;
        e.ct = ct; e.top = top; e.cn = cn; e.nx = nx;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        ba.FLUSH = 0; ba.FLUSH_ADDR = '0; ba.WR_VALID = 0; ba.WR_DATA = '0; ba.POP = 0; ba.POP2 = 0;
    endtask

    task automatic idle_b();
        bb.FLUSH = 0; bb.FLUSH_ADDR = '0; bb.WR_VALID = 0; bb.WR_DATA = '0; bb.POP = 0; bb.POP2 = 0;
    endtask

    // behavioural model of the 6-byte / 16-bit build as a plain byte queue
    task automatic mstep(bit fl, logic [15:0] fad, bit wv, logic [15:0] wd, bit p, bit p2);
        int fill;
        int rem;
        bit rq;
        if (fl) begin
            mq.delete();
            m_top = fad;
            m_fa  = fad;
        end else begin
            fill = m_fa[0] ? 1 : 2;
            rq   = (6 - mq.size()) >= fill;
            rem  = (p2 && mq.size() >= 2) ? 2 : ((p || p2) && mq.size() >= 1) ? 1 : 0;
            repeat (rem) begin
                mq.delete(0);
                m_top = m_top + 16'd1;
            end
            if (wv && rq) begin
                if (fill == 1) mq.push_back(wd[15:8]);
                else begin
                    mq.push_back(wd[7:0]);
                    mq.push_back(wd[15:8]);
                end
                m_fa = m_fa + 16'(fill);
            end
        end
    endtask

    task automatic mexp(string nm);
        int s;
        s = mq.size();
        ex(1, nm, s, m_top, m_fa, (6 - s) >= (m_fa[0] ? 1 : 2),
           s >= 1, (s >= 1) ? mq[0] : 8'h00, s >= 2, (s >= 2) ? mq[1] : 8'h00);
    endtask

    initial begin
        exp_t        e;
        logic [15:0] c, a, f;
        logic        r, em, nv;
        logic [7:0]  t, n;
        forever begin
            @(negedge clk);
            chk("inv_a", ba.FETCH_ADDR, ba.PFQ_ADDR_OUT + 16'(ba.PFQ_COUNT));
            chk("inv_b", bb.FETCH_ADDR, bb.PFQ_ADDR_OUT + 16'(bb.PFQ_COUNT));
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.dut == 0) begin
                    c = 16'(ba.PFQ_COUNT); a = ba.PFQ_ADDR_OUT; f = ba.FETCH_ADDR; r = ba.FETCH_REQ;
                    t = ba.PFQ_TOP_BYTE; n = ba.PFQ_NEXT_BYTE; em = ba.PFQ_EMPTY; nv = ba.PFQ_NEXT_VALID;
                end else begin
                    c = 16'(bb.PFQ_COUNT); a = bb.PFQ_ADDR_OUT; f = bb.FETCH_ADDR; r = bb.FETCH_REQ;
                    t = bb.PFQ_TOP_BYTE; n = bb.PFQ_NEXT_BYTE; em = bb.PFQ_EMPTY; nv = bb.PFQ_NEXT_VALID;
                end
                chk({e.nm, " count"}, c, 16'(e.cnt));
                chk({e.nm, " addr_out"}, a, e.addr);
                chk({e.nm, " fetch_addr"}, f, e.fa);
                chk({e.nm, " fetch_req"}, 16'(r), 16'(e.rq));
                chk({e.nm, " empty"}, 16'(em), 16'(e.cnt == 0));
                chk({e.nm, " next_valid"}, 16'(nv), 16'(e.cnt >= 2));
                if (e.ct) chk({e.nm, " top_byte"}, 16'(t), 16'(e.top));
                if (e.cn) chk({e.nm, " next_byte"}, 16'(n), 16'(e.nx));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          fl, wv, p, p2;
        logic [15:0] fad, wd;
        rst_a = 0; rst_b = 0;
        idle_a(); idle_b();
        tick();
        ex(0, "rst_a", 0, 16'h0000, 16'h0000, 1, 1, 8'h00, 1, 8'h00);
        ex(1, "rst_b", 0, 16'h1230, 16'h1230, 1, 1, 8'h00, 1, 8'h00);
        rst_a = 1; rst_b = 1;

        for (int i = 0; i < 4; i++) begin
            ba.WR_VALID = 1; ba.WR_DATA = 8'hA0 + 8'(i);
            tick();
            ex(0, "a_fill", i + 1, 16'h0000, 16'(i + 1), i < 3, 1, 8'hA0, i >= 1, 8'hA1);
        end
        ba.WR_DATA = 8'hEE;
        tick(); ex(0, "a_full_ignored", 4, 16'h0000, 16'h0004, 0, 1, 8'hA0, 1, 8'hA1);
        ba.WR_VALID = 0; ba.POP2 = 1;
        tick(); ex(0, "a_pop2", 2, 16'h0002, 16'h0004, 1, 1, 8'hA2, 1, 8'hA3);
        ba.POP2 = 0; ba.POP = 1;
        tick(); ex(0, "a_pop", 1, 16'h0003, 16'h0004, 1, 1, 8'hA3);
        ba.POP = 0; ba.POP2 = 1;
        tick(); ex(0, "a_pop2_count1", 0, 16'h0004, 16'h0004, 1);
        ba.POP2 = 0; ba.POP = 1;
        tick(); ex(0, "a_pop_empty", 0, 16'h0004, 16'h0004, 1);
        ba.WR_VALID = 1; ba.WR_DATA = 8'hC5;
        tick(); ex(0, "a_wr_pop_empty", 1, 16'h0004, 16'h0005, 1, 1, 8'hC5);
        idle_a();

        bb.FLUSH = 1; bb.FLUSH_ADDR = 16'h0101;
        tick(); ex(1, "b_flush", 0, 16'h0101, 16'h0101, 1);
        bb.FLUSH = 0; bb.WR_VALID = 1; bb.WR_DATA = 16'h3412;
        tick(); ex(1, "b_odd_fill", 1, 16'h0101, 16'h0102, 1, 1, 8'h34);
        bb.WR_DATA = 16'h7856;
        tick(); ex(1, "b_even_fill", 3, 16'h0101, 16'h0104, 1, 1, 8'h34, 1, 8'h56);
        bb.WR_DATA = 16'hBA9A;
        tick(); ex(1, "b_full_even", 5, 16'h0101, 16'h0106, 0, 1, 8'h34, 1, 8'h56);
        bb.WR_DATA = 16'hFFFF; bb.POP = 1;
        tick(); ex(1, "b_pop_at_full", 4, 16'h0102, 16'h0106, 1, 1, 8'h56, 1, 8'h78);
        bb.WR_VALID = 0;
        tick(); ex(1, "b_pop", 3, 16'h0103, 16'h0106, 1, 1, 8'h78, 1, 8'h9A);
        bb.WR_VALID = 1; bb.WR_DATA = 16'hDCBC; bb.POP = 0; bb.POP2 = 1;
        tick(); ex(1, "b_wr_pop2_wrap", 3, 16'h0105, 16'h0108, 1, 1, 8'hBA, 1, 8'hBC);
        idle_b();
        mq = '{8'hBA, 8'hBC, 8'hDC};
        m_top = 16'h0105;
        m_fa  = 16'h0108;

        for (int i = 0; i < 50; i++) begin
            fl  = $urandom_range(0, 19) == 0;
            fad = 16'($urandom);
            wv  = $urandom_range(0, 3) != 0;
            wd  = 16'($urandom);
            p   = $urandom_range(0, 1) == 1;
            p2  = $urandom_range(0, 2) == 0;
            bb.FLUSH = fl; bb.FLUSH_ADDR = fad; bb.WR_VALID = wv; bb.WR_DATA = wd; bb.POP = p; bb.POP2 = p2;
            tick();
            mstep(fl, fad, wv, wd, p, p2);
            mexp("b_random");
        end

        bb.FLUSH = 1; bb.FLUSH_ADDR = 16'hFFFF; bb.WR_VALID = 1; bb.WR_DATA = 16'h5566; bb.POP = 1; bb.POP2 = 0;
        tick(); ex(1, "b_flush_priority", 0, 16'hFFFF, 16'hFFFF, 1);
        bb.FLUSH = 0; bb.POP = 0; bb.WR_DATA = 16'h11EE;
        tick(); ex(1, "b_ip_wrap", 1, 16'hFFFF, 16'h0000, 1, 1, 8'h11);
        bb.WR_DATA = 16'h3322; bb.POP = 1;
        tick(); ex(1, "b_wr_pop", 2, 16'h0000, 16'h0002, 1, 1, 8'h22, 1, 8'h33);
        rst_b = 0; bb.POP = 0; bb.WR_DATA = 16'h5544;
        tick(); ex(1, "b_reset_mid_fill", 0, 16'h1230, 16'h1230, 1, 1, 8'h00, 1, 8'h00);
        rst_b = 1; bb.WR_VALID = 0;
        tick(); ex(1, "b_after_reset", 0, 16'h1230, 16'h1230, 1, 1, 8'h00, 1, 8'h00);
        idle_b();

        repeat (3) @(negedge clk);
        #1;
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
